// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_arb_pkg
// Description : Shared types and constants for the FIFO write arbiter.
//               - arb_state_e : two-state arbiter FSM encoding
//               - C_BURST_*   : legal range of the BURST parameter
//               - C_BEAT_W    : width of the per-grant beat counter
//               - C_STALL_*   : stall statistics counter width / saturation
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int C_BURST_MIN = 1;
    localparam int C_BURST_MAX = 16;
    // Beat counter only ever holds 0..BURST-1, so 4 bits cover BURST=16.
    localparam int C_BEAT_W    = $clog2(C_BURST_MAX);

    localparam int          C_STALL_W   = 16;
    localparam logic [15:0] C_STALL_MAX = 16'hFFFF;

endpackage : fifo_arb_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Purely combinational round-robin picker. Searches the request
//               vector starting at last_i+1, wrapping to 0, and returns the
//               first set bit.
// Ports       : req_i   [NREQ-1:0] request vector
//               last_i  [IDW-1:0]  index of the previous winner
//               found_o            at least one request set
//               idx_o   [IDW-1:0]  winning index (last_i when none found)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  last_i,
    output logic            found_o,
    output logic [IDW-1:0]  idx_o
);

    logic [IDW-1:0] cand;

    // Offsets 1..NREQ visit every requester once, ending at last_i itself,
    // so a sole requester that just finished its grant can win again.
    always_comb begin
        found_o = 1'b0;
        idx_o   = last_i;
        cand    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(last_i) + k) % NREQ);
            if (!found_o && req_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/fifo_wr_arb.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arb
// Description : Round-robin arbiter that lets NREQ requesters write bursts of
//               up to BURST beats into a single FIFO write port. One idle
//               bubble cycle is spent choosing each grant holder.
// Ports       : clk, rst (async, active-high)
//               req_valid[NREQ], req_data[NREQ*WIDTH], req_ready[NREQ]
//               wr_en, wr_data[WIDTH], wr_full
//               grant_id[$clog2(NREQ)], busy, stall_cnt[16]
// Options     : FIFO_WR_ARB_STATS_EN - when defined, stall_cnt counts GRANT
//               cycles blocked by wr_full (saturating); otherwise tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arb
    import fifo_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int BURST = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*WIDTH-1:0]    req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic                     wr_en,
    output logic [WIDTH-1:0]         wr_data,
    input  logic                     wr_full,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     busy,
    output logic [C_STALL_W-1:0]     stall_cnt
);

    localparam int                  IDW       = $clog2(NREQ);
    localparam logic [C_BEAT_W-1:0] BEAT_LAST = C_BEAT_W'(BURST - 1);

    arb_state_e          state_q, state_d;
    logic [IDW-1:0]      grant_id_q, grant_id_d;
    logic [IDW-1:0]      last_q, last_d;
    logic [C_BEAT_W-1:0] beat_q, beat_d;

    logic                pick_found;
    logic [IDW-1:0]      pick_idx;
    logic                grant_valid;
    logic                xfer;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_pick (
        .req_i   (req_valid),
        .last_i  (last_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    assign grant_valid = req_valid[grant_id_q];
    assign xfer        = (state_q == GRANT) && grant_valid && !wr_full;

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        last_d     = last_q;
        beat_d     = beat_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_id_d = pick_idx;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                // A full FIFO with the holder still valid simply holds the
                // grant: neither branch below fires.
                if ((xfer && (beat_q == BEAT_LAST)) || !grant_valid) begin
                    state_d = IDLE;
                    last_d  = grant_id_q;
                    beat_d  = '0;
                end else if (xfer) begin
                    beat_d = beat_q + C_BEAT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_id_q <= '0;
            last_q     <= IDW'(NREQ - 1);
            beat_q     <= '0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            last_q     <= last_d;
            beat_q     <= beat_d;
        end
    end

    always_comb begin
        req_ready             = '0;
        req_ready[grant_id_q] = xfer;
    end

    assign wr_en    = xfer;
    assign wr_data  = req_data[grant_id_q*WIDTH +: WIDTH];
    assign grant_id = grant_id_q;
    assign busy     = (state_q == GRANT);

`ifdef FIFO_WR_ARB_STATS_EN
    logic [C_STALL_W-1:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (busy && grant_valid && wr_full && (stall_q != C_STALL_MAX)) begin
            stall_d = stall_q + C_STALL_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule : fifo_wr_arb
`default_nettype wire

// File: tb/tb_fifo_wr_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_wr_arb
// Description : Self-checking bench for fifo_wr_arb. Expected writes are
//               queued when stimulus is applied and popped by a write
//               monitor; cycle-level behaviour is checked directly.
//               A second instance with BURST=1 checks single-beat alternation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arb;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic [NREQ-1:0]         req_valid = '0;
    logic [NREQ*WIDTH-1:0]   req_data;
    logic [NREQ-1:0]         req_ready;
    logic                    wr_en;
    logic [WIDTH-1:0]        wr_data;
    logic                    wr_full = 1'b0;
    logic [1:0]              grant_id;
    logic                    busy;
    logic [15:0]             stall_cnt;

    logic [NREQ-1:0]         v1 = '0;
    logic [NREQ-1:0]         rdy1;
    logic                    wen1;
    logic [WIDTH-1:0]        wd1;
    logic [1:0]              gid1;
    logic                    busy1;
    logic [15:0]             st1;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } beat_t;

    beat_t sb[$];
    beat_t mon_e;

    always #5 clk = ~clk;

    fifo_wr_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .BURST(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .wr_full   (wr_full),
        .grant_id  (grant_id),
        .busy      (busy),
        .stall_cnt (stall_cnt)
    );

    fifo_wr_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .BURST(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (v1),
        .req_data  (req_data),
        .req_ready (rdy1),
        .wr_en     (wen1),
        .wr_data   (wd1),
        .wr_full   (1'b0),
        .grant_id  (gid1),
        .busy      (busy1),
        .stall_cnt (st1)
    );

    function automatic logic [7:0] dat(input logic [1:0] id);
        return 8'hA0 + 8'h11 * {6'b0, id};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic exp_write(input logic [1:0] id);
        sb.push_back('{id: id, data: dat(id)});
    endtask

    // Advance to the next cycle, apply inputs just after the edge and
    // return at the falling edge where outputs are sampled.
    task automatic next_cycle(input logic [NREQ-1:0] v, input logic f);
        @(posedge clk);
        #1;
        req_valid = v;
        wr_full   = f;
        @(negedge clk);
    endtask

    // Write monitor: every write must match the oldest expected beat.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL sb_unexpected_write observed=%0h expected=none", {grant_id, wr_data});
            end
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                checks++;
                assert ({grant_id, wr_data} === {mon_e.id, mon_e.data}) else begin
                    errors++;
                    $error("FAIL sb_write observed=%0h expected=%0h", {grant_id, wr_data}, {mon_e.id, mon_e.data});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        req_data = {dat(2'd3), dat(2'd2), dat(2'd1), dat(2'd0)};
        #1 rst = 1'b1;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wr_en",    32'(wr_en),     32'd0);
        chk("rst_busy",     32'(busy),      32'd0);
        chk("rst_ready",    32'(req_ready), 32'd0);
        chk("rst_grant_id", 32'(grant_id),  32'd0);
        chk("rst_stall",    32'(stall_cnt), 32'd0);

        // ---------------- all requesters: 0,1,2,3,0 x4 beats ----------------
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = 4'hF;
        @(negedge clk);
        chk("rr_bubble0_busy",  32'(busy),  32'd0);
        chk("rr_bubble0_wr_en", 32'(wr_en), 32'd0);
        for (int c = 1; c <= 24; c++) begin
            logic       exp_busy;
            logic [1:0] exp_id;
            exp_busy = (c % 5) != 0;
            exp_id   = 2'((c / 5) % 4);
            if (exp_busy) exp_write(exp_id);
            next_cycle(4'hF, 1'b0);
            chk($sformatf("rr_busy_c%0d", c),  32'(busy),  32'(exp_busy));
            chk($sformatf("rr_wr_en_c%0d", c), 32'(wr_en), 32'(exp_busy));
            chk($sformatf("rr_ready_c%0d", c), 32'(req_ready),
                exp_busy ? (32'd1 << exp_id) : 32'd0);
            if (exp_busy)
                chk($sformatf("rr_grant_c%0d", c), 32'(grant_id), 32'(exp_id));
        end
        next_cycle(4'h0, 1'b0);
        chk("rr_end_busy",     32'(busy),     32'd0);
        chk("rr_end_grant_id", 32'(grant_id), 32'd0);

        // ---------------- requester 2 alone, 3 beats then drop ----------------
        next_cycle(4'b0100, 1'b0);
        chk("solo_bubble_busy", 32'(busy), 32'd0);
        for (int b = 0; b < 3; b++) begin
            exp_write(2'd2);
            next_cycle(4'b0100, 1'b0);
            chk("solo_grant_id", 32'(grant_id),  32'd2);
            chk("solo_wr_en",    32'(wr_en),     32'd1);
            chk("solo_ready",    32'(req_ready), 32'b0100);
        end
        next_cycle(4'b0000, 1'b0);
        chk("solo_drop_wr_en", 32'(wr_en),     32'd0);
        chk("solo_drop_ready", 32'(req_ready), 32'd0);
        next_cycle(4'b0000, 1'b0);
        chk("solo_idle_busy",  32'(busy),     32'd0);
        chk("solo_idle_hold",  32'(grant_id), 32'd2);

        // ---------------- full stall of 5 cycles mid-burst ----------------
        next_cycle(4'b1000, 1'b0);
        chk("stall_bubble_busy", 32'(busy), 32'd0);
        for (int b = 0; b < 2; b++) begin
            exp_write(2'd3);
            next_cycle(4'b1000, 1'b0);
            chk("stall_pre_wr_en", 32'(wr_en), 32'd1);
        end
        // Other requesters raise valid during the stall; the grant must hold.
        for (int s = 0; s < 5; s++) begin
            next_cycle(4'b1111, 1'b1);
            chk("stall_wr_en",    32'(wr_en),     32'd0);
            chk("stall_ready",    32'(req_ready), 32'd0);
            chk("stall_grant_id", 32'(grant_id),  32'd3);
            chk("stall_busy",     32'(busy),      32'd1);
        end
        for (int b = 0; b < 2; b++) begin
            exp_write(2'd3);
            next_cycle(4'b1000, 1'b0);
            chk("stall_post_wr_en",    32'(wr_en),    32'd1);
            chk("stall_post_grant_id", 32'(grant_id), 32'd3);
        end
        next_cycle(4'b0000, 1'b0);
        chk("stall_done_busy", 32'(busy), 32'd0);
`ifdef FIFO_WR_ARB_STATS_EN
        chk("stall_cnt", 32'(stall_cnt), 32'd5);
`else
        chk("stall_cnt", 32'(stall_cnt), 32'd0);
`endif

        // ---------------- reset during beat 2 of a grant to requester 1 ----------------
        next_cycle(4'b0010, 1'b0);
        chk("arst_bubble_busy", 32'(busy), 32'd0);
        exp_write(2'd1);
        next_cycle(4'b0010, 1'b0);
        chk("arst_beat1_grant", 32'(grant_id), 32'd1);
        chk("arst_beat1_wr_en", 32'(wr_en),    32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_wr_en",    32'(wr_en),     32'd0);
        chk("arst_ready",    32'(req_ready), 32'd0);
        chk("arst_busy",     32'(busy),      32'd0);
        chk("arst_grant_id", 32'(grant_id),  32'd0);
        chk("arst_stall",    32'(stall_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = 4'b0011;
        @(negedge clk);
        chk("arst_rel_busy", 32'(busy), 32'd0);
        for (int b = 0; b < 4; b++) begin
            exp_write(2'd0);
            next_cycle(4'b0011, 1'b0);
            chk("arst_rel_grant", 32'(grant_id), 32'd0);
            chk("arst_rel_wr_en", 32'(wr_en),    32'd1);
        end
        next_cycle(4'b0000, 1'b0);
        chk("arst_end_busy", 32'(busy), 32'd0);

        // ---------------- BURST=1 instance: requesters 1 and 3 alternate ----------------
        for (int c = 0; c < 8; c++) begin
            logic       exp_wr;
            logic [1:0] exp_id;
            exp_wr = (c % 2) == 1;
            exp_id = ((c % 4) == 1) ? 2'd1 : 2'd3;
            @(posedge clk);
            #1;
            v1 = 4'b1010;
            @(negedge clk);
            chk($sformatf("b1_wr_en_c%0d", c), 32'(wen1), 32'(exp_wr));
            if (exp_wr) begin
                chk($sformatf("b1_grant_c%0d", c), 32'(gid1), 32'(exp_id));
                chk($sformatf("b1_data_c%0d", c),  32'(wd1),  32'(dat(exp_id)));
                chk($sformatf("b1_ready_c%0d", c), 32'(rdy1), 32'd1 << exp_id);
            end
        end
        @(posedge clk);
        #1;
        v1 = '0;

        @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fifo_wr_arb
`default_nettype wire
